// File: rtl/res_ram_streamer_if.sv
// AXI4-Stream beat channel carrying the result words out of res_ram_streamer.
interface res_ram_streamer_if #(
  parameter int width = 8
);
  logic [width-1:0] TDATA;
  logic             TVALID;
  logic             TREADY;
  logic             TLAST;

  modport master (output TDATA, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/res_ram_streamer.sv
// Reads NUMBER_OF_OUTPUT_WORDS words back from RES_RAM and emits them as one AXI4-Stream packet.
// Defining RES_HEADER_EN prepends a beat carrying the word count.
module res_ram_streamer #(
  parameter int width                  = 8,
  parameter int RES_depth_bits         = 6,
  parameter int NUMBER_OF_OUTPUT_WORDS = 64
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      Start,
  output logic                      Busy,
  output logic                      Done,
  output logic                      RES_read_en,
  output logic [RES_depth_bits-1:0] RES_read_address,
  input  logic [width-1:0]          RES_read_data_out,
  res_ram_streamer_if.master        M_AXIS
);

`ifdef RES_HEADER_EN
  localparam int HDR_BEATS = 1;
  localparam logic [width-1:0] HDR_WORD = width'(NUMBER_OF_OUTPUT_WORDS);
`else
  localparam int HDR_BEATS = 0;
`endif
  localparam int CW = RES_depth_bits + 2;
  localparam logic [CW-1:0] N_WORDS   = CW'(NUMBER_OF_OUTPUT_WORDS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NUMBER_OF_OUTPUT_WORDS + HDR_BEATS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t                    state_reg, state_next;
  logic [CW-1:0]             iss_reg, iss_next;
  logic [CW-1:0]             beat_reg, beat_next;
  logic                      rd_en_reg, rd_en_next;
  logic [RES_depth_bits-1:0] rd_addr_reg, rd_addr_next;
  logic                      f_reg, f_next;
  logic                      out_valid_reg, out_valid_next;
  logic [width-1:0]          out_data_reg, out_data_next;
  logic                      tlast_reg, tlast_next;
  logic [1:0]                skid_cnt_reg, skid_cnt_next;
  logic [1:0][width-1:0]     skid_data_reg, skid_data_next;
  logic                      busy_reg, busy_next;
  logic                      done_reg, done_next;
  logic                      pop;
  logic                      ins;
  logic [width-1:0]          ins_data;
  logic [2:0]                committed;
`ifdef RES_HEADER_EN
  logic                      hdr_reg, hdr_next;
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= IDLE;
      iss_reg       <= '0;
      beat_reg      <= '0;
      rd_en_reg     <= 1'b0;
      rd_addr_reg   <= '0;
      f_reg         <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      tlast_reg     <= 1'b0;
      skid_cnt_reg  <= '0;
      skid_data_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
`ifdef RES_HEADER_EN
      hdr_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      iss_reg       <= iss_next;
      beat_reg      <= beat_next;
      rd_en_reg     <= rd_en_next;
      rd_addr_reg   <= rd_addr_next;
      f_reg         <= f_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      tlast_reg     <= tlast_next;
      skid_cnt_reg  <= skid_cnt_next;
      skid_data_reg <= skid_data_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
`ifdef RES_HEADER_EN
      hdr_reg       <= hdr_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    iss_next       = iss_reg;
    beat_next      = beat_reg;
    rd_en_next     = 1'b0;
    rd_addr_next   = rd_addr_reg;
    f_next         = rd_en_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    tlast_next     = tlast_reg;
    skid_cnt_next  = skid_cnt_reg;
    skid_data_next = skid_data_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    pop            = out_valid_reg & M_AXIS.TREADY;
    ins            = f_reg;
    ins_data       = RES_read_data_out;
    committed      = '0;
`ifdef RES_HEADER_EN
    hdr_next       = hdr_reg;
    if (hdr_reg) begin
      ins      = 1'b1;
      ins_data = HDR_WORD;
      hdr_next = 1'b0;
    end
`endif

    unique case (state_reg)
      IDLE: begin
        if (Start) begin
          state_next = STREAM;
          busy_next  = 1'b1;
          iss_next   = '0;
          beat_next  = '0;
`ifdef RES_HEADER_EN
          // Word 0 is fetched one cycle early so it lands right behind the header beat.
          rd_en_next   = 1'b1;
          rd_addr_next = '0;
          iss_next     = CW'(1);
          hdr_next     = 1'b1;
`endif
        end
      end
      STREAM: begin
        if (pop) begin
          beat_next = beat_reg + CW'(1);
          if (skid_cnt_reg != 2'd0) begin
            out_data_next     = skid_data_reg[0];
            skid_data_next[0] = skid_data_reg[1];
            skid_cnt_next     = skid_cnt_reg - 2'd1;
          end else begin
            out_valid_next = 1'b0;
          end
        end
        if (ins) begin
          if (!out_valid_next) begin
            out_valid_next = 1'b1;
            out_data_next  = ins_data;
          end else begin
            skid_data_next[skid_cnt_next[0]] = ins_data;
            skid_cnt_next                    = skid_cnt_next + 2'd1;
          end
        end
        // Every issued read must have a free slot even if TREADY stays low from now on.
        committed = 3'(out_valid_next) + 3'(skid_cnt_next) + 3'(rd_en_reg);
        if (iss_reg < N_WORDS && committed <= 3'd2) begin
          rd_en_next   = 1'b1;
          rd_addr_next = iss_reg[RES_depth_bits-1:0];
          iss_next     = iss_reg + CW'(1);
        end
        tlast_next = out_valid_next && (beat_next == LAST_BEAT);
        if (pop && beat_reg == LAST_BEAT) begin
          state_next = FINISH;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Busy             = busy_reg;
  assign Done             = done_reg;
  assign RES_read_en      = rd_en_reg;
  assign RES_read_address = rd_addr_reg;
  assign M_AXIS.TDATA     = out_data_reg;
  assign M_AXIS.TVALID    = out_valid_reg;
  assign M_AXIS.TLAST     = tlast_reg;

endmodule
